// File: rtl/drone_cam_arbiter.sv
// Arbiter for the shared camera/image-scan unit: fixed priority for manual control,
// round-robin between thermal search and self-test, with a BUSY watchdog timer.
module drone_cam_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic       cam_start,
  output logic       timeout_err,
  output logic [3:0] err_count,
  output logic [1:0] state_out
);

  localparam logic [1:0] StIdle    = 2'b00;
  localparam logic [1:0] StGrant   = 2'b01;
  localparam logic [1:0] StBusy    = 2'b10;
  localparam logic [1:0] StRelease = 2'b11;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic       cam_start_q, cam_start_d;
  logic       timeout_err_q, timeout_err_d;
  logic [3:0] err_count_q, err_count_d;
  logic [7:0] timer_q, timer_d;
  logic       rr_q, rr_d;
  logic [2:0] winner;

  // Manual control always wins; rr only breaks the thermal/self-test tie.
  always_comb begin
    winner = 3'b000;
    if (req[0]) begin
      winner = 3'b001;
    end else if (req[1] && req[2]) begin
      winner = rr_q ? 3'b100 : 3'b010;
    end else if (req[1]) begin
      winner = 3'b010;
    end else if (req[2]) begin
      winner = 3'b100;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cam_start_d   = 1'b0;
    timeout_err_d = 1'b0;
    err_count_d   = err_count_q;
    timer_d       = timer_q;
    rr_d          = rr_q;

    case (state_q)
      StIdle: begin
        grant_d = 3'b000;
        timer_d = 8'd0;
        if (req != 3'b000) begin
          state_d     = StGrant;
          grant_d     = winner;
          cam_start_d = 1'b1;
          if (winner[1]) begin
            rr_d = 1'b1;
          end else if (winner[2]) begin
            rr_d = 1'b0;
          end
        end
      end
      StGrant: begin
        timer_d = 8'd0;
        state_d = StBusy;
      end
      StBusy: begin
        timer_d = timer_q + 8'd1;
        // done takes precedence over an expiring watchdog on the same cycle.
        if (done) begin
          state_d = StRelease;
          grant_d = 3'b000;
        end else if (timer_q == TimerLast) begin
          state_d       = StRelease;
          grant_d       = 3'b000;
          timeout_err_d = 1'b1;
          if (err_count_q != 4'hF) begin
            err_count_d = err_count_q + 4'd1;
          end
        end
      end
      StRelease: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
      default: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 3'b000;
      cam_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      err_count_q   <= 4'd0;
      timer_q       <= 8'd0;
      rr_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      cam_start_q   <= cam_start_d;
      timeout_err_q <= timeout_err_d;
      err_count_q   <= err_count_d;
      timer_q       <= timer_d;
      rr_q          <= rr_d;
    end
  end

  assign grant       = grant_q;
  assign cam_start   = cam_start_q;
  assign timeout_err = timeout_err_q;
  assign err_count   = err_count_q;
  assign state_out   = state_q;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));
  a_start_in_grant: assert property (@(posedge clk) cam_start_q |-> (state_q == StGrant));

endmodule

// File: tb/tb_drone_cam_arbiter.sv
// Directed bench for drone_cam_arbiter: arbitration order, watchdog, saturation and reset.
module tb_drone_cam_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic       done;
  logic [2:0] grant;
  logic       cam_start;
  logic       timeout_err;
  logic [3:0] err_count;
  logic [1:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  drone_cam_arbiter #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .cam_start  (cam_start),
    .timeout_err(timeout_err),
    .err_count  (err_count),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // From IDLE with req held: grant, nbusy extra BUSY cycles, done, release, idle.
  task automatic run_op(input string tag, input logic [2:0] exp_grant, input int nbusy);
    tick();
    check({tag, "_g_state"}, 32'(state_out), 32'd1);
    check({tag, "_g_grant"}, 32'(grant), 32'(exp_grant));
    check({tag, "_g_start"}, 32'(cam_start), 32'd1);
    tick();
    check({tag, "_b_state"}, 32'(state_out), 32'd2);
    check({tag, "_b_start"}, 32'(cam_start), 32'd0);
    for (int i = 0; i < nbusy; i++) begin
      tick();
      check({tag, "_b_hold"}, 32'(grant), 32'(exp_grant));
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check({tag, "_r_state"}, 32'(state_out), 32'd3);
    check({tag, "_r_grant"}, 32'(grant), 32'd0);
    check({tag, "_r_terr"}, 32'(timeout_err), 32'd0);
    tick();
    check({tag, "_i_state"}, 32'(state_out), 32'd0);
    check({tag, "_i_grant"}, 32'(grant), 32'd0);
  endtask

  // From IDLE with req=100 held and done low: watchdog expiry.
  task automatic timeout_op(input int exp_cnt);
    tick();
    tick();
    check("to_busy_entry", 32'(state_out), 32'd2);
    repeat (15) tick();
    check("to_busy_t15", 32'(state_out), 32'd2);
    check("to_no_early_err", 32'(timeout_err), 32'd0);
    tick();
    check("to_rel_state", 32'(state_out), 32'd3);
    check("to_err_pulse", 32'(timeout_err), 32'd1);
    check("to_err_count", 32'(err_count), 32'(exp_cnt));
    check("to_rel_grant", 32'(grant), 32'd0);
    tick();
    check("to_err_cleared", 32'(timeout_err), 32'd0);
    check("to_idle", 32'(state_out), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b111;
    done  = 1'b1;
    repeat (3) tick();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(cam_start), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);

    // Single request
    do_reset();
    req = 3'b010;
    run_op("single", 3'b010, 0);
    req = 3'b000;
    tick();
    check("single_stay_idle", 32'(state_out), 32'd0);

    // Contention: alternation starting at bit1
    do_reset();
    req = 3'b110;
    run_op("rr0", 3'b010, 2);
    run_op("rr1", 3'b100, 2);
    run_op("rr2", 3'b010, 2);

    // Priority: bit0 grants leave rr at 0
    do_reset();
    req = 3'b111;
    run_op("prio0", 3'b001, 1);
    run_op("prio1", 3'b001, 1);
    req = 3'b110;
    run_op("prio_rr", 3'b010, 1);

    // done ignored in IDLE and GRANT
    req  = 3'b000;
    done = 1'b1;
    tick();
    check("done_idle_state", 32'(state_out), 32'd0);
    done = 1'b0;
    req  = 3'b010;
    tick();
    check("dg_grant_state", 32'(state_out), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 3'b000;
    check("done_in_grant", 32'(state_out), 32'd2);
    tick();
    check("dg_busy_held", 32'(state_out), 32'd2);
    check("dg_busy_grant", 32'(grant), 32'b010);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("dg_release", 32'(state_out), 32'd3);
    tick();

    // Watchdog and saturation
    do_reset();
    req = 3'b100;
    for (int i = 1; i <= 20; i++) timeout_op((i > 15) ? 15 : i);
    check("to_saturated", 32'(err_count), 32'd15);

    // Reset on BUSY cycle 5, done pulsed during reset
    tick();
    tick();
    repeat (5) tick();
    check("mid_busy_state", 32'(state_out), 32'd2);
    reset = 1'b1;
    done  = 1'b1;
    tick();
    check("mid_rst_state", 32'(state_out), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    check("mid_rst_terr", 32'(timeout_err), 32'd0);
    done = 1'b0;
    tick();
    reset = 1'b0;
    req   = 3'b000;
    tick();
    check("post_rst_idle", 32'(state_out), 32'd0);
    check("post_rst_terr", 32'(timeout_err), 32'd0);

    // done and watchdog expiry on the same cycle
    req = 3'b100;
    tick();
    tick();
    repeat (15) tick();
    check("sim_busy_t15", 32'(state_out), 32'd2);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 3'b000;
    check("sim_rel_state", 32'(state_out), 32'd3);
    check("sim_no_terr", 32'(timeout_err), 32'd0);
    check("sim_cnt", 32'(err_count), 32'd0);
    tick();
    check("sim_idle", 32'(state_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
